// File: rtl/m_ram8_pkg.sv
`default_nettype none
// ============================================================================
// Module      : m_ram8_pkg
// Description : Shared CPU constants and helpers for the 8-word register file.
// Revision    : 1.0 - initial release
// ============================================================================
package m_ram8_pkg;

    localparam int c_WIDTH = 16;
    localparam int c_DEPTH = 8;
    localparam int c_AW    = 3;

    localparam logic [7:0] c_CNT_MAX = 8'hFF;

    // Counter increment that sticks at the maximum instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        return (value == c_CNT_MAX) ? value : value + 8'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/m_dmux8way.sv
`default_nettype none
// ============================================================================
// Module      : m_dmux8way
// Description : 1-to-8 demultiplexer; routes i_in to the selected output only.
// Revision    : 1.0 - initial release
// ============================================================================
module m_dmux8way
    import m_ram8_pkg::*;
#(
    parameter int AW = c_AW
) (
    input  logic          i_in,
    input  logic [AW-1:0] i_sel,
    output logic [7:0]    o_out
);

    always_comb begin
        o_out        = '0;
        o_out[i_sel] = i_in;
    end

endmodule
`default_nettype wire

// File: rtl/m_mux8way16.sv
`default_nettype none
// ============================================================================
// Module      : m_mux8way16
// Description : Combinational 8:1 word multiplexer.
// Revision    : 1.0 - initial release
// ============================================================================
module m_mux8way16
    import m_ram8_pkg::*;
#(
    parameter int WIDTH = c_WIDTH,
    parameter int AW    = c_AW
) (
    input  logic [7:0][WIDTH-1:0] i_data,
    input  logic [AW-1:0]         i_sel,
    output logic [WIDTH-1:0]      o_out
);

    assign o_out = i_data[i_sel];

endmodule
`default_nettype wire

// File: rtl/m_register16.sv
`default_nettype none
// ============================================================================
// Module      : m_register16
// Description : Load-enabled data register with asynchronous active-high reset.
// Revision    : 1.0 - initial release
// ============================================================================
module m_register16
    import m_ram8_pkg::*;
#(
    parameter int WIDTH = c_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_in,
    input  logic             i_load,
    output logic [WIDTH-1:0] o_out
);

    logic [WIDTH-1:0] r_data;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_in;
        end
    end

    assign o_out = r_data;

endmodule
`default_nettype wire

// File: rtl/m_ram8.sv
`default_nettype none
// ============================================================================
// Module      : m_ram8
// Description : 8-word register file with zero-latency read, write-busy flag
//               and saturating write counter.
// Revision    : 1.0 - initial release
// ============================================================================
module m_ram8
    import m_ram8_pkg::*;
#(
    parameter int WIDTH = c_WIDTH,
    parameter int DEPTH = c_DEPTH,
    parameter int AW    = c_AW
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_in,
    input  logic             i_load,
    input  logic [AW-1:0]    i_addr,
    output logic [WIDTH-1:0] o_out,
    output logic             o_busy,
    output logic [7:0]       o_wr_cnt
);

    logic [DEPTH-1:0]            w_load_sel;
    logic [DEPTH-1:0][WIDTH-1:0] w_words;
    logic                        r_busy;
    logic [7:0]                  r_wr_cnt;

    m_dmux8way #(
        .AW    (AW)
    ) u_dmux (
        .i_in  (i_load),
        .i_sel (i_addr),
        .o_out (w_load_sel)
    );

    for (genvar g = 0; g < DEPTH; g++) begin : g_regs
        m_register16 #(
            .WIDTH  (WIDTH)
        ) u_reg (
            .i_clk  (i_clk),
            .i_rst  (i_rst),
            .i_in   (i_in),
            .i_load (w_load_sel[g]),
            .o_out  (w_words[g])
        );
    end

    // Read is unregistered, so a same-cycle write is only visible after the edge.
    m_mux8way16 #(
        .WIDTH  (WIDTH),
        .AW     (AW)
    ) u_mux (
        .i_data (w_words),
        .i_sel  (i_addr),
        .o_out  (o_out)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_busy   <= 1'b0;
            r_wr_cnt <= 8'd0;
        end else begin
            r_busy <= i_load;
            if (i_load) begin
                r_wr_cnt <= sat_inc(r_wr_cnt);
            end
        end
    end

    assign o_busy   = r_busy;
    assign o_wr_cnt = r_wr_cnt;

endmodule
`default_nettype wire

// File: doc/m_ram8.md
M_RAM8 -- requirements
Module: m_ram8

Interface
REQ-001 Parameter WIDTH, default 16, data word width in bits.
REQ-002 Parameter DEPTH, default 8, number of registers; fixed at 8 for this block.
REQ-003 Parameter AW, default 3, address width; AW = log2(DEPTH).
REQ-004 i_clk  input  1  single clock; all state updates on rising edge.
REQ-005 i_rst  input  1  reset, asynchronous, active-high.
REQ-006 i_in  input  WIDTH  write data word.
REQ-007 i_load  input  1  write enable; write i_in to register i_addr on the next rising edge.
REQ-008 i_addr  input  AW  register select, shared by the write and read paths.
REQ-009 o_out  output  WIDTH  contents of register i_addr.
REQ-010 o_busy  output  1  high for exactly the cycle after any accepted write.
REQ-011 o_wr_cnt  output  8  saturating count of accepted writes since reset.

Function
REQ-012 Write path: an 8-way one-hot demux of i_load by i_addr; only the selected register loads, and all others hold.
REQ-013 Write latency: the register updates on the rising edge where i_load=1; the new value is visible on o_out from that edge onward.
REQ-014 Read path: o_out = reg[i_addr], combinational 8:1 mux, zero-cycle read latency.
REQ-015 Same address read and written in one cycle: o_out shows the old value until the edge, then the new value; there is no bypass.
REQ-016 i_addr change with i_load=0: o_out follows within the same cycle and no register changes.
REQ-017 i_load held high across N cycles: N writes, each to the i_addr and i_in present at its edge.
REQ-018 o_busy is registered and equals the i_load sampled at the previous edge.
REQ-019 o_wr_cnt increments by 1 per accepted write and saturates at 255 with no wrap.
REQ-020 X/Z on i_addr while i_load=1: behaviour is undefined; the bench shall not drive it.
REQ-021 All addresses 0..7 are valid; there is no out-of-range case.

Reset
REQ-022 While i_rst=1: all registers, o_busy and o_wr_cnt are forced to 0 immediately, without waiting for a clock edge.
REQ-023 During reset: o_out = 0 for every i_addr.
REQ-024 Reset asserted in the same cycle as i_load=1: reset wins and no write occurs.
REQ-025 First write is accepted on the first rising edge after i_rst deasserts.

Structure
REQ-026 WIDTH, DEPTH and AW defaults shall live in the shared CPU constants package/include; no local redefinition.
REQ-027 The one-hot decode shall be a separate sub-module, m_dmux8way (1-bit input, AW-bit select, 8 outputs).
REQ-028 Storage shall be 8 instances of the team's 16-bit load register; no inferred memory arrays.
REQ-029 The read mux shall reuse the existing 16-bit mux tree (m_mux8way16).

Verification
REQ-030 Reset, then read all addresses 0..7 -> o_out=0x0000 for each; o_wr_cnt=0; o_busy=0.
REQ-031 Write 0x1111*k to address k for k=0..7, then read back -> each address returns its value; o_wr_cnt=8.
REQ-032 Write 0xBEEF to address 3 while reading address 3 -> o_out=old 0x3333 before the edge and 0xBEEF after it; no other address changes.
REQ-033 Write 0xAAAA to address 5, then assert i_rst mid-cycle with i_load=1 -> all registers are 0 immediately, address 5 reads 0x0000, and o_wr_cnt=0.
REQ-034 Perform 300 consecutive writes -> o_wr_cnt saturates at 255; o_busy stays high from the second cycle through the cycle after the last write.
REQ-035 Hold i_load=0 and sweep i_addr -> o_out tracks stored contents and no register changes.
